// File: rtl/ws2812b_scheduler.sv
// WS2812B frame scheduler: presents NUM_LEDS GRB words to a bit serializer,
// waits for the line to drain, then holds the latch gap. Optional: PENDING_REFRESH_EN.
module ws2812b_scheduler #(
  parameter int NUM_LEDS     = 12,
  parameter int LATCH_CYCLES = 2400
) (
  input  logic                clk,
  input  logic                res,
  input  logic                refresh,
  input  logic [NUM_LEDS-1:0] led_mask,
  input  logic [7:0]          intensity,
  input  logic [2:0]          colour,
  output logic [23:0]         pix_data,
  output logic                pix_valid,
  input  logic                pix_ready,
  input  logic                ser_idle,
  output logic                busy,
  output logic                frame_done
);

  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATCH_CYCLES - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_SEND      = 2'd1;
  localparam logic [1:0] S_WAIT_IDLE = 2'd2;
  localparam logic [1:0] S_LATCH     = 2'd3;

  // GRB word for one pixel; channel order in en is {G,R,B}
  function automatic logic [23:0] pix_word(input logic lit, input logic [2:0] en,
                                           input logic [7:0] level);
    pix_word = {(lit & en[2]) ? level : 8'h00,
                (lit & en[1]) ? level : 8'h00,
                (lit & en[0]) ? level : 8'h00};
  endfunction

  logic [1:0]          state_r, state_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [NUM_LEDS-1:0] mask_sh_r, mask_src_s;
  logic [7:0]          intensity_sh_r, intensity_src_s;
  logic [2:0]          colour_sh_r, colour_src_s;
  logic [23:0]         pix_data_r;
  logic                pix_valid_r, valid_s;
  logic                busy_r, frame_done_r, frame_done_s;
  logic                capture_s, restart_s;

`ifdef PENDING_REFRESH_EN
  logic pending_r;

  assign restart_s = pending_r | refresh;

  // Remember a refresh that arrives mid-frame; consumed when the latch gap ends
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      pending_r <= 1'b0;
    end else if (state_r == S_LATCH && cnt_r == CNT_LAST) begin
      pending_r <= 1'b0;
    end else if (refresh && state_r != S_IDLE) begin
      pending_r <= 1'b1;
    end else begin
      pending_r <= pending_r;
    end
  end
`else
  assign restart_s = 1'b0;
`endif

  // Next-state, index, latch counter and capture decisions
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    valid_s   = pix_valid_r;
    case (state_r)
      S_IDLE: begin
        if (refresh) begin
          capture_s = 1'b1;
          idx_s     = '0;
          valid_s   = 1'b1;
          state_s   = S_SEND;
        end else begin
          valid_s   = 1'b0;
        end
      end
      S_SEND: begin
        if (pix_valid_r && pix_ready) begin
          if (idx_r == IDX_LAST) begin
            valid_s = 1'b0;
            state_s = S_WAIT_IDLE;
          end else begin
            idx_s   = idx_r + IDX_W'(1);
          end
        end else begin
          idx_s = idx_r;
        end
      end
      S_WAIT_IDLE: begin
        if (ser_idle) begin
          cnt_s   = '0;
          state_s = S_LATCH;
        end else begin
          cnt_s   = cnt_r;
        end
      end
      S_LATCH: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s = '0;
          if (restart_s) begin
            capture_s = 1'b1;
            idx_s     = '0;
            valid_s   = 1'b1;
            state_s   = S_SEND;
          end else begin
            state_s   = S_IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  assign mask_src_s      = capture_s ? led_mask  : mask_sh_r;
  assign intensity_src_s = capture_s ? intensity : intensity_sh_r;
  assign colour_src_s    = capture_s ? colour    : colour_sh_r;
  // frame_done marks the final cycle spent in LATCH
  assign frame_done_s    = (state_s == S_LATCH) && (cnt_s == CNT_LAST);

  // State, shadow and registered output update
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_r        <= S_IDLE;
      idx_r          <= '0;
      cnt_r          <= '0;
      mask_sh_r      <= '0;
      intensity_sh_r <= 8'h00;
      colour_sh_r    <= 3'b000;
      pix_data_r     <= 24'h000000;
      pix_valid_r    <= 1'b0;
      busy_r         <= 1'b0;
      frame_done_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      cnt_r        <= cnt_s;
      pix_valid_r  <= valid_s;
      pix_data_r   <= valid_s ? pix_word(mask_src_s[idx_s], colour_src_s, intensity_src_s)
                              : 24'h000000;
      busy_r       <= (state_s != S_IDLE);
      frame_done_r <= frame_done_s;
      if (capture_s) begin
        mask_sh_r      <= led_mask;
        intensity_sh_r <= intensity;
        colour_sh_r    <= colour;
      end
    end
  end

  assign pix_data   = pix_data_r;
  assign pix_valid  = pix_valid_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_ws2812b_scheduler.sv
// Self-checking bench for ws2812b_scheduler: a frame-level reference model
// checked every cycle, plus directed scenarios pinned to literal expectations.
module tb_ws2812b_scheduler;

  localparam int NL      = 12;
  localparam int LATCH_P = 40;
`ifdef PENDING_REFRESH_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          refresh = 1'b0;
  logic [NL-1:0] led_mask = '0;
  logic [7:0]    intensity = 8'h00;
  logic [2:0]    colour = 3'b000;
  logic [23:0]   pix_data;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic          ser_idle = 1'b0;
  logic          busy;
  logic          frame_done;

  int tests = 0;
  int fails = 0;

  ws2812b_scheduler #(.NUM_LEDS(NL), .LATCH_CYCLES(LATCH_P)) dut (
    .clk(clk), .res(res), .refresh(refresh), .led_mask(led_mask),
    .intensity(intensity), .colour(colour), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .ser_idle(ser_idle),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words still owed to the serializer, a
  // waiting-for-drain flag and a countdown of latch cycles left.
  logic [23:0] m_q[$];
  bit          m_wait = 1'b0;
  int          m_left = 0;
  bit          m_pend = 1'b0;
  logic [23:0] acc_q[$];

  function automatic logic [23:0] exp_word(input logic lit, input logic [2:0] c,
                                           input logic [7:0] lvl);
    logic [23:0] w;
    w[23:16] = (lit && c[2]) ? lvl : 8'h00;
    w[15:8]  = (lit && c[1]) ? lvl : 8'h00;
    w[7:0]   = (lit && c[0]) ? lvl : 8'h00;
    return w;
  endfunction

  task automatic model_load();
    for (int i = 0; i < NL; i++) m_q.push_back(exp_word(led_mask[i], colour, intensity));
  endtask

  function automatic bit model_busy();
    return (m_q.size() != 0) || m_wait || (m_left != 0);
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge res);
      if (res) begin
        m_q.delete();
        m_wait = 1'b0;
        m_left = 0;
        m_pend = 1'b0;
      end else begin
        bit was_busy;
        bit restart;
        was_busy = model_busy();
        restart  = 1'b0;
        if (m_q.size() != 0) begin
          if (pix_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_wait = 1'b1;
          end
        end else if (m_wait) begin
          if (ser_idle) begin
            m_wait = 1'b0;
            m_left = LATCH_P;
          end
        end else if (m_left != 0) begin
          m_left--;
          if (m_left == 0) restart = PEND_EN && (m_pend || refresh);
        end
        if (PEND_EN && was_busy && refresh) m_pend = 1'b1;
        if (restart) begin
          m_pend = 1'b0;
          model_load();
        end else if (!was_busy && refresh) begin
          model_load();
        end
      end
    end
  end

  // Compare process plus accepted-word recorder, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      check("pix_valid", {23'd0, pix_valid}, {23'd0, m_q.size() != 0});
      check("pix_data", pix_data, (m_q.size() != 0) ? m_q[0] : 24'h000000);
      check("busy", {23'd0, busy}, {23'd0, model_busy()});
      check("frame_done", {23'd0, frame_done}, {23'd0, m_left == 1});
      if (!res && pix_valid && pix_ready) acc_q.push_back(pix_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_refresh(input logic [NL-1:0] m, input logic [7:0] lvl, input logic [2:0] c);
    led_mask  = m;
    intensity = lvl;
    colour    = c;
    refresh   = 1'b1;
    tick();
    refresh   = 1'b0;
  endtask

  task automatic wait_acc(input int n);
    int guard = 0;
    while (acc_q.size() < n && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    #1;
    if (acc_q.size() < n) check("accept_timeout", 24'(acc_q.size()), 24'(n));
  endtask

  initial begin
    int base;
    int n;
    #1 res = 1'b1;
    tick();
    tick();
    check("rst_pix_valid", {23'd0, pix_valid}, 24'd0);
    check("rst_pix_data", pix_data, 24'h000000);
    check("rst_busy", {23'd0, busy}, 24'd0);
    check("rst_frame_done", {23'd0, frame_done}, 24'd0);
    res = 1'b0;
    tick();
    check("no_frame_without_refresh", {23'd0, pix_valid}, 24'd0);

    // single lit first pixel, back-to-back transfer
    pix_ready = 1'b1;
    base = acc_q.size();
    pulse_refresh(12'h001, 8'h20, 3'b111);
    check("busy_after_refresh", {23'd0, busy}, 24'd1);
    check("valid_after_refresh", {23'd0, pix_valid}, 24'd1);
    repeat (11) tick();
    check("valid_at_word11", {23'd0, pix_valid}, 24'd1);
    tick();
    check("valid_after_word11", {23'd0, pix_valid}, 24'd0);
    check("frame1_count", 24'(acc_q.size() - base), 24'd12);
    check("frame1_word0", acc_q[base], 24'h202020);
    for (int i = 1; i < NL; i++) check("frame1_word_zero", acc_q[base + i], 24'h000000);

    // latch gap length after a late ser_idle
    repeat (10) tick();
    check("busy_waiting_idle", {23'd0, busy}, 24'd1);
    ser_idle = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_done && n < LATCH_P + 50);
    check("latch_length", 24'(n), 24'(LATCH_P));
    tick();
    check("busy_after_done", {23'd0, busy}, 24'd0);
    check("done_single_pulse", {23'd0, frame_done}, 24'd0);
    ser_idle = 1'b0;

    // red-only last pixel
    base = acc_q.size();
    pulse_refresh(12'h800, 8'h08, 3'b010);
    wait_acc(base + 12);
    check("frame2_word11", acc_q[base + 11], 24'h000800);
    check("frame2_word0", acc_q[base], 24'h000000);
    ser_idle = 1'b1;
    repeat (LATCH_P + 3) tick();
    check("frame2_idle", {23'd0, busy}, 24'd0);
    ser_idle = 1'b0;

    // back-pressure on word 3
    base = acc_q.size();
    pulse_refresh(12'h008, 8'h5A, 3'b101);
    wait_acc(base + 3);
    pix_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", {23'd0, pix_valid}, 24'd1);
      check("stall_data", pix_data, 24'h5A005A);
      tick();
    end
    pix_ready = 1'b1;
    tick();
    check("after_stall_word4", pix_data, 24'h000000);
    check("after_stall_count", 24'(acc_q.size() - base), 24'd4);
    wait_acc(base + 12);
    ser_idle = 1'b1;
    repeat (LATCH_P + 3) tick();
    ser_idle = 1'b0;

    // refresh arriving mid-SEND
    ser_idle = 1'b1;
    base = acc_q.size();
    pulse_refresh(12'h0F0, 8'h11, 3'b001);
    repeat (3) tick();
    pulse_refresh(12'hF00, 8'h33, 3'b100);
    repeat (2 * LATCH_P + 40) tick();
    check("midsend_count", 24'(acc_q.size() - base), PEND_EN ? 24'd24 : 24'd12);
    check("midsend_first_word4", acc_q[base + 4], 24'h000011);
    if (PEND_EN) check("pending_word8", acc_q[base + 20], 24'h330000);
    ser_idle = 1'b0;

    // reset in the middle of a frame
    base = acc_q.size();
    pulse_refresh(12'h040, 8'h44, 3'b111);
    wait_acc(base + 6);
    check("pre_reset_word6", pix_data, 24'h444444);
    res = 1'b1;
    #1;
    check("midreset_valid", {23'd0, pix_valid}, 24'd0);
    check("midreset_data", pix_data, 24'h000000);
    check("midreset_busy", {23'd0, busy}, 24'd0);
    tick();
    res = 1'b0;
    tick();
    check("post_reset_quiet", {23'd0, pix_valid}, 24'd0);
    base = acc_q.size();
    pulse_refresh(12'h001, 8'h10, 3'b001);
    wait_acc(base + 1);
    check("restart_word0", acc_q[base], 24'h000010);
    wait_acc(base + 12);
    ser_idle = 1'b1;
    repeat (LATCH_P + 3) tick();
    ser_idle = 1'b0;

    // randomized traffic, model compared every cycle
    for (int c = 0; c < 4000; c++) begin
      refresh   = ($urandom_range(0, 15) == 0);
      pix_ready = ($urandom_range(0, 3) != 0);
      ser_idle  = ($urandom_range(0, 5) == 0);
      led_mask  = NL'($urandom);
      intensity = 8'($urandom);
      colour    = 3'($urandom);
      res       = ($urandom_range(0, 699) == 0);
      tick();
    end
    res = 1'b0;
    refresh = 1'b0;
    pix_ready = 1'b1;
    ser_idle = 1'b1;
    repeat (2 * LATCH_P + 40) tick();
    check("final_idle", {23'd0, busy}, 24'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ws2812b_scheduler.md
WS2812B_SCHEDULER -- requirements
Module: ws2812b_scheduler

Interface
REQ-001 Parameter NUM_LEDS, default 12, number of pixels per frame (ring size).
REQ-002 Parameter LATCH_CYCLES, default 2400, clk cycles of line-low latch gap (60 us at 40 MHz).
REQ-003 clk  input  1  clock (40 MHz).
REQ-004 res  input  1  reset, asynchronous, active-high.
REQ-005 refresh  input  1  single-cycle frame start request.
REQ-006 led_mask  input  NUM_LEDS  per-pixel lit flag, bit 0 = first pixel sent.
REQ-007 intensity  input  8  channel value applied to lit pixels.
REQ-008 colour  input  3  channel enables {G,R,B} = colour[2:0].
REQ-009 pix_data  output  24  GRB word to bit serializer, G in [23:16].
REQ-010 pix_valid  output  1  pix_data valid.
REQ-011 pix_ready  input  1  serializer accepts word when pix_valid & pix_ready.
REQ-012 ser_idle  input  1  serializer has shifted out its last bit.
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 frame_done  output  1  one-cycle pulse at end of latch gap.

Function
REQ-015 States SHALL be IDLE, SEND, WAIT_IDLE, LATCH; encoding free.
REQ-016 In IDLE, refresh=1 SHALL capture led_mask, intensity, colour into shadow registers, clear pixel index, and enter SEND; pix_valid rises the next cycle.
REQ-017 Inputs led_mask, intensity, colour SHALL be ignored outside the capture cycle.
REQ-018 In SEND, pix_data SHALL equal, per channel c in {G,R,B}: (mask_sh[idx] & colour_sh[c]) ? intensity_sh : 8'h00.
REQ-019 pix_data and pix_valid SHALL hold stable while pix_valid & !pix_ready.
REQ-020 On acceptance with idx < NUM_LEDS-1: idx increments, pix_valid stays high, next word presented the following cycle (back-to-back: one word per cycle).
REQ-021 On acceptance with idx = NUM_LEDS-1: pix_valid SHALL drop next cycle; enter WAIT_IDLE.
REQ-022 In WAIT_IDLE, ser_idle=1 SHALL enter LATCH with latch counter cleared.
REQ-023 LATCH SHALL last exactly LATCH_CYCLES cycles; on the last, frame_done pulses one cycle and state returns to IDLE (or see REQ-029).
REQ-024 Counter widths SHALL be $clog2 of their ranges; idx never exceeds NUM_LEDS-1; no wrap of latch counter.
REQ-025 refresh while busy SHALL not alter the frame in progress.
REQ-026 pix_data SHALL be 0 whenever pix_valid=0.

Reset
REQ-027 res=1 SHALL immediately force IDLE, pix_valid=0, pix_data=0, busy=0, frame_done=0, idx=0, counters=0, shadow regs=0, pending flag=0, including mid-frame.
REQ-028 First frame after reset release SHALL require a new refresh pulse.

Configuration
REQ-029 With PENDING_REFRESH_EN defined: refresh while busy sets a pending flag; at LATCH end the scheduler captures inputs and enters SEND directly (frame_done still pulses; flag cleared). Without: refresh while busy is dropped.

Verification
REQ-030 Reset, refresh with led_mask=12'h001, intensity=8'h20, colour=3'b111, pix_ready=1 -> word0 24'h202020, words1..11 24'h000000 on 12 consecutive cycles, busy high from cycle after refresh.
REQ-031 colour=3'b010, led_mask=12'h800, intensity=8'h08 -> word11 = 24'h000800, others 0.
REQ-032 pix_ready held low 5 cycles on word 3 -> pix_data/pix_valid unchanged for 5 cycles, then word 4 follows.
REQ-033 ser_idle asserted 10 cycles after last accept -> frame_done exactly LATCH_CYCLES cycles after entering LATCH; busy low the cycle after.
REQ-034 refresh mid-SEND: without macro no second frame; with PENDING_REFRESH_EN second frame's pix_valid rises cycle after frame_done using inputs sampled then.
REQ-035 res asserted at idx=6 -> outputs zero same cycle; subsequent refresh restarts at idx 0.
